// File: rtl/stack_ctrl.sv
// Full-descending CPU stack sequencer: owns SP and runs push/pop/peek/drop over a req/ack memory port.
// Optional SP_BOUNDS_CHECK_EN enables overflow/underflow detection at command acceptance.
module stack_ctrl #(
  parameter logic [15:0] STACK_BASE  = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'hF000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] din_i,
  output logic [15:0] dout_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        sp_load_i,
  input  logic [15:0] sp_din_i,
  output logic [15:0] sp_out_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i
);

  localparam logic [1:0] OpPush = 2'b00;
  localparam logic [1:0] OpPop  = 2'b01;
  localparam logic [1:0] OpPeek = 2'b10;

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  state_e      state_q;
  logic [15:0] sp_q, dout_q, mem_addr_q, mem_wdata_q;
  logic        mem_req_q, mem_we_q, done_q, err_q, pop_q;
  logic        bound_err;

  always_comb begin
    bound_err = 1'b0;
`ifdef SP_BOUNDS_CHECK_EN
    if (cmd_op_i == OpPush) bound_err = (sp_q == STACK_LIMIT);
    else                    bound_err = (sp_q == STACK_BASE);
`endif
  end

`ifndef SP_BOUNDS_CHECK_EN
  logic unused_limit;
  assign unused_limit = ^STACK_LIMIT;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sp_q        <= STACK_BASE;
      dout_q      <= 16'h0000;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pop_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          // SP load wins over a simultaneous command; the command stays pending.
          if (sp_load_i) begin
            sp_q <= sp_din_i;
          end else if (cmd_valid_i) begin
            pop_q <= (cmd_op_i == OpPop);
            if (bound_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              case (cmd_op_i)
                OpPush: begin
                  mem_addr_q  <= sp_q - 16'd1;
                  mem_wdata_q <= din_i;
                  mem_we_q    <= 1'b1;
                  mem_req_q   <= 1'b1;
                  state_q     <= StWr;
                end
                OpPop, OpPeek: begin
                  mem_addr_q <= sp_q;
                  mem_we_q   <= 1'b0;
                  mem_req_q  <= 1'b1;
                  state_q    <= StRd;
                end
                default: begin
                  sp_q    <= sp_q + 16'd1;
                  state_q <= StDone;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end
        StWr: begin
          if (mem_ack_i) begin
            sp_q      <= sp_q - 16'd1;
            mem_req_q <= 1'b0;
            state_q   <= StDone;
            done_q    <= 1'b1;
          end
        end
        StRd: begin
          if (mem_ack_i) begin
            dout_q    <= mem_rdata_i;
            mem_req_q <= 1'b0;
            if (pop_q) sp_q <= sp_q + 16'd1;
            state_q   <= StDone;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign dout_o      = dout_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign sp_out_o    = sp_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random commands against a stack/memory model.
module tb_stack_ctrl;

  localparam logic [15:0] Base  = 16'h0000;
  localparam logic [15:0] Limit = 16'hF000;
  localparam logic [1:0]  OpPush = 2'b00, OpPop = 2'b01, OpPeek = 2'b10, OpDrop = 2'b11;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] din = 16'h0, dout;
  logic        done, err;
  logic        sp_load = 1'b0;
  logic [15:0] sp_din = 16'h0, sp_out;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: SP, last read result, and what the stack memory should hold.
  logic [15:0] sp_m   = Base;
  logic [15:0] dout_m = 16'h0;
  logic [15:0] ref_mem [logic [15:0]];
  // Memory as seen from the bus (written only by DUT write transactions).
  logic [15:0] mem_arr [logic [15:0]];

  always #5 clk = ~clk;

  stack_ctrl #(.STACK_BASE(Base), .STACK_LIMIT(Limit)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .din_i(din), .dout_o(dout), .done_o(done), .err_o(err),
    .sp_load_i(sp_load), .sp_din_i(sp_din), .sp_out_o(sp_out),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] bus_rd(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 16'h0000;
  endfunction

  task automatic load_sp(input logic [15:0] v);
    sp_load = 1'b1;
    sp_din  = v;
    @(negedge clk);
    sp_load = 1'b0;
    sp_m    = v;
    chk("sp_after_load", sp_out, sp_m);
  endtask

  // Called at a negedge; issues one command and checks it through to the next idle cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] d, input int dly);
    logic [15:0] exp_addr, a;
    logic        exp_err, is_mem;
    int          guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk1("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    din       = d;
    exp_err   = 1'b0;
`ifdef SP_BOUNDS_CHECK_EN
    exp_err = (op == OpPush) ? (sp_m == Limit) : (sp_m == Base);
`endif
    is_mem   = !exp_err && (op != OpDrop);
    exp_addr = (op == OpPush) ? sp_m - 16'd1 : sp_m;
    if (!exp_err) begin
      case (op)
        OpPush: begin a = sp_m - 16'd1; ref_mem[a] = d; sp_m = a; end
        OpPop:  begin dout_m = ref_rd(sp_m); sp_m = sp_m + 16'd1; end
        OpPeek: dout_m = ref_rd(sp_m);
        default: sp_m = sp_m + 16'd1;
      endcase
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (is_mem) begin
      for (int k = 0; k <= dly; k++) begin
        chk1("mem_req_wait", mem_req, 1'b1);
        chk("mem_addr", mem_addr, exp_addr);
        chk1("mem_we", mem_we, op == OpPush);
        if (op == OpPush) chk("mem_wdata", mem_wdata, d);
        chk1("done_early", done, 1'b0);
        // SP load while busy must be ignored.
        sp_load = (k == 0);
        sp_din  = 16'h5A5A;
        if (k == dly) begin
          mem_ack = 1'b1;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = bus_rd(mem_addr);
        end
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      sp_load   = 1'b0;
    end
    chk1("done_pulse", done, 1'b1);
    chk1("err", err, exp_err);
    chk1("mem_req_after", mem_req, 1'b0);
    chk1("ready_in_done", cmd_ready, 1'b0);
    chk("sp_out", sp_out, sp_m);
    chk("dout", dout, dout_m);
    @(negedge clk);
    chk1("done_one_cycle", done, 1'b0);
    chk1("ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_ready", cmd_ready, 1'b1);
    chk("rst_sp", sp_out, Base);
    chk("rst_dout", dout, 16'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);

`ifndef SP_BOUNDS_CHECK_EN
    // Push/pop round trip from empty with wrap below zero
    run_cmd(OpPush, 16'hBEEF, 0);
    chk("push_sp_wrap", sp_out, 16'hFFFF);
    run_cmd(OpPop, 16'h0000, 0);
    chk("pop_dout", dout, 16'hBEEF);
    chk("pop_sp", sp_out, 16'h0000);
`else
    load_sp(16'h0010);
    run_cmd(OpPush, 16'hBEEF, 0);
    run_cmd(OpPop, 16'h0000, 0);
    chk("pop_dout", dout, 16'hBEEF);
`endif

    // Peek with a slow memory
    run_cmd(OpPeek, 16'h0000, 3);

    // SP load beats a simultaneous command; command accepted the next cycle
    sp_load   = 1'b1;
    sp_din    = 16'h1234;
    cmd_valid = 1'b1;
    cmd_op    = OpDrop;
    @(negedge clk);
    sp_load = 1'b0;
    sp_m    = 16'h1234;
    chk("load_prio_sp", sp_out, 16'h1234);
    chk1("load_prio_ready", cmd_ready, 1'b1);
    chk1("load_prio_done", done, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    sp_m      = 16'h1235;
    chk1("drop_done", done, 1'b1);
    chk("drop_sp", sp_out, 16'h1235);
    chk1("drop_no_req", mem_req, 1'b0);
    @(negedge clk);

    // Reset in the middle of a write transaction
    cmd_valid = 1'b1;
    cmd_op    = OpPush;
    din       = 16'h1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk1("midwr_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midwr_req_drop", mem_req, 1'b0);
    chk("midwr_sp", sp_out, Base);
    @(negedge clk);
    rst_n  = 1'b1;
    sp_m   = Base;
    dout_m = 16'h0;
    @(negedge clk);
    chk1("midwr_ready", cmd_ready, 1'b1);
    chk1("midwr_no_done", done, 1'b0);

    // Boundary behaviour
`ifdef SP_BOUNDS_CHECK_EN
    run_cmd(OpPop, 16'h0, 0);
    chk1("underflow_err", err, 1'b1);
    load_sp(Limit);
    run_cmd(OpPush, 16'hAAAA, 0);
    chk("overflow_sp", sp_out, Limit);
`else
    load_sp(16'hFFFF);
    run_cmd(OpPop, 16'h0, 1);
    chk("pop_wrap_sp", sp_out, 16'h0000);
`endif

    // Random command stream
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       load_sp(Base);
          1:       load_sp(Limit + 16'd1);
          default: load_sp(16'($urandom));
        endcase
      end
      run_cmd(2'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
